sdcard_loader: RTL and testbench

- Boot-time DMA stage directly downstream of the SD card interface block.
- Drives that block's command/sector interface and pulls sector bytes one per cycle.
- Packs bytes little-endian into 32-bit words and writes them to RAM (PSRAM/cache port) through a valid/ready write handshake.
- Copies SectorCount consecutive sectors starting at StartSector to DestAddress, then pulses done.

---
 rtl/sdcard_loader.sv | 182 ++++++++++++++++++
 tb/tb_sdcard_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_loader.sv
// Boot-time copier: reads consecutive SD sectors byte by byte, packs them little-endian
// into 32-bit words and writes them to RAM through a valid/ready handshake.
module sdcard_loader #(
  parameter logic [31:0] StartSector = 32'd0,
  parameter int unsigned SectorCount = 8,
  parameter logic [31:0] DestAddress = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  sd_command,
  output logic [31:0] sd_sector,
  input  logic [7:0]  sd_data,
  input  logic        sd_busy,
  output logic        mem_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_CARD   = 3'd1,
    ST_START_READ  = 3'd2,
    ST_WAIT_READ   = 3'd3,
    ST_READ_BYTE   = 3'd4,
    ST_WRITE_WORD  = 3'd5,
    ST_NEXT_SECTOR = 3'd6
  } state_t;

  localparam logic [31:0] LastSector = 32'(SectorCount - 1);

  state_t      state_r, state_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [1:0]  sd_command_r, sd_command_s;
  logic [31:0] sd_sector_r, sd_sector_s;
  logic        mem_enable_r, mem_enable_s;
  logic [31:0] mem_address_r, mem_address_s;
  logic [31:0] mem_data_r, mem_data_s;
  logic [8:0]  byte_cnt_r, byte_cnt_s;
  logic [31:0] sector_cnt_r, sector_cnt_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign sd_command  = sd_command_r;
  assign sd_sector   = sd_sector_r;
  assign mem_enable  = mem_enable_r;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      sd_command_r  <= 2'd0;
      sd_sector_r   <= 32'd0;
      mem_enable_r  <= 1'b0;
      mem_address_r <= DestAddress;
      mem_data_r    <= 32'd0;
      byte_cnt_r    <= 9'd0;
      sector_cnt_r  <= 32'd0;
    end else begin
      state_r       <= state_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      sd_command_r  <= sd_command_s;
      sd_sector_r   <= sd_sector_s;
      mem_enable_r  <= mem_enable_s;
      mem_address_r <= mem_address_s;
      mem_data_r    <= mem_data_s;
      byte_cnt_r    <= byte_cnt_s;
      sector_cnt_r  <= sector_cnt_s;
    end
  end

  // Next-state logic; outputs are computed from the next state so they line up with it
  always_comb begin
    state_s       = state_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    sd_command_s  = 2'd0;
    sd_sector_s   = sd_sector_r;
    mem_enable_s  = 1'b0;
    mem_address_s = mem_address_r;
    mem_data_s    = mem_data_r;
    byte_cnt_s    = byte_cnt_r;
    sector_cnt_s  = sector_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s       = ST_WAIT_CARD;
          busy_s        = 1'b1;
          sector_cnt_s  = 32'd0;
          mem_address_s = DestAddress;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_CARD: begin
        if (!sd_busy) begin
          state_s = ST_START_READ;
        end else begin
          state_s = ST_WAIT_CARD;
        end
      end
      ST_START_READ: begin
        byte_cnt_s = 9'd0;
        state_s    = ST_WAIT_READ;
      end
      ST_WAIT_READ: begin
        if (!sd_busy) begin
          state_s = ST_READ_BYTE;
        end else begin
          state_s = ST_WAIT_READ;
        end
      end
      ST_READ_BYTE: begin
        case (byte_cnt_r[1:0])
          2'd0:    mem_data_s[7:0]   = sd_data;
          2'd1:    mem_data_s[15:8]  = sd_data;
          2'd2:    mem_data_s[23:16] = sd_data;
          2'd3:    mem_data_s[31:24] = sd_data;
          default: mem_data_s        = mem_data_r;
        endcase
        byte_cnt_s = byte_cnt_r + 9'd1;
        if (byte_cnt_r[1:0] == 2'd3) begin
          state_s = ST_WRITE_WORD;
        end else begin
          state_s = ST_READ_BYTE;
        end
      end
      ST_WRITE_WORD: begin
        if (mem_ready) begin
          mem_address_s = mem_address_r + 32'd4;
          // byte counter wrapped to zero means all 512 bytes of the sector are out
          if (byte_cnt_r == 9'd0) begin
            state_s = ST_NEXT_SECTOR;
            if (sector_cnt_r == LastSector) begin
              done_s = 1'b1;
              busy_s = 1'b0;
            end else begin
              done_s = 1'b0;
            end
          end else begin
            state_s = ST_READ_BYTE;
          end
        end else begin
          state_s = ST_WRITE_WORD;
        end
      end
      ST_NEXT_SECTOR: begin
        if (sector_cnt_r == LastSector) begin
          state_s = ST_IDLE;
        end else begin
          sector_cnt_s = sector_cnt_r + 32'd1;
          state_s      = ST_START_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase

    case (state_s)
      ST_START_READ: begin
        sd_command_s = 2'd1;
        sd_sector_s  = StartSector + sector_cnt_s;
      end
      ST_READ_BYTE:  sd_command_s = 2'd2;
      ST_WRITE_WORD: mem_enable_s = 1'b1;
      default:       sd_command_s = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_sdcard_loader.sv
// Scoreboard bench for sdcard_loader: SD block model, stallable memory model and
// a queue of expected words/sectors built when each copy is started.
`timescale 1ns/1ps
module tb_sdcard_loader;

  localparam logic [31:0] START_SEC = 32'd5;
  localparam int          N_SEC     = 3;
  localparam logic [31:0] DEST      = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [1:0]  sd_command;
  logic [31:0] sd_sector;
  logic [7:0]  sd_data;
  logic        sd_busy;
  logic        mem_enable;
  logic [31:0] mem_address, mem_data;
  logic        mem_ready;

  always #5 clk = ~clk;

  sdcard_loader #(
    .StartSector(START_SEC),
    .SectorCount(N_SEC),
    .DestAddress(DEST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .sd_command(sd_command), .sd_sector(sd_sector), .sd_data(sd_data),
    .sd_busy(sd_busy), .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_data(mem_data), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Sector k of the run starting at START_SEC holds bytes i + 16*k, so sector 5 is i & 0xFF
  function automatic logic [7:0] pat(input logic [31:0] sec, input logic [8:0] idx);
    logic [31:0] d;
    d = sec - START_SEC;
    return idx[7:0] + {d[3:0], 4'h0};
  endfunction

  // SD block model
  logic        card_hold = 1'b0;
  int          init_cnt, rd_cnt;
  logic [8:0]  sd_idx;
  logic [31:0] sd_cur;
  always @(posedge clk) begin
    if (!rst_n) begin
      init_cnt <= 10; rd_cnt <= 0; sd_idx <= 9'd0; sd_cur <= 32'd0;
    end else begin
      if (init_cnt != 0) init_cnt <= init_cnt - 1;
      if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      if (sd_command == 2'd1) begin
        sd_cur <= sd_sector; sd_idx <= 9'd0; rd_cnt <= 3;
      end else if (sd_command == 2'd2) begin
        sd_idx <= sd_idx + 9'd1;
      end
    end
  end
  assign sd_busy = card_hold || (init_cnt != 0) || (rd_cnt != 0);
  assign sd_data = pat(sd_cur, sd_idx);

  // Memory model: accept after `stall` cycles of mem_enable
  int stall = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    if (mem_enable && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                          wait_cnt <= 0;
  end
  assign mem_ready = mem_enable && (wait_cnt >= stall);

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_sec_q[$];

  task automatic push_expected();
    logic [31:0] w, sec;
    for (int k = 0; k < N_SEC; k++) begin
      sec = START_SEC + 32'(k);
      exp_sec_q.push_back(sec);
      for (int j = 0; j < 128; j++) begin
        w = {pat(sec, 9'(4*j+3)), pat(sec, 9'(4*j+2)), pat(sec, 9'(4*j+1)), pat(sec, 9'(4*j))};
        exp_data_q.push_back(w);
        exp_addr_q.push_back(DEST + 32'((k*128 + j)*4));
      end
    end
  endtask

  // Monitor, sampled on the falling edge
  int          wr_cnt = 0, cmd1_cnt = 0, cmd2_cnt = 0, done_cnt = 0;
  logic        held = 1'b0;
  logic [31:0] prev_addr, prev_data;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sd_command == 2'd1) begin
        cmd1_cnt <= cmd1_cnt + 1;
        if (exp_sec_q.size() > 0) check("sd_sector", sd_sector, exp_sec_q.pop_front());
        else                      check("extra_read", 32'd1, 32'd0);
      end
      if (sd_command == 2'd2) cmd2_cnt <= cmd2_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (held) begin
        check("hold_en",   32'(mem_enable), 32'd1);
        check("hold_addr", mem_address, prev_addr);
        check("hold_data", mem_data, prev_data);
        check("stall_cmd", 32'(sd_command), 32'd0);
      end
      if (mem_enable && mem_ready) begin
        wr_cnt <= wr_cnt + 1;
        if (exp_addr_q.size() > 0) begin
          check("wr_addr", mem_address, exp_addr_q.pop_front());
          check("wr_data", mem_data, exp_data_q.pop_front());
        end else begin
          check("unexpected_write", 32'd1, 32'd0);
        end
      end
      held      <= mem_enable && !mem_ready;
      prev_addr <= mem_address;
      prev_data <= mem_data;
    end else begin
      held <= 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_cmd"},   32'(sd_command), 32'd0);
    check({tag, "_sect"},  sd_sector, 32'd0);
    check({tag, "_men"},   32'(mem_enable), 32'd0);
    check({tag, "_maddr"}, mem_address, DEST);
    check({tag, "_mdata"}, mem_data, 32'd0);
  endtask

  task automatic full_run(input string tag, input int budget, input bit restart_mid);
    int wr0, c1, c2, d0;
    wr0 = wr_cnt; c1 = cmd1_cnt; c2 = cmd2_cnt; d0 = done_cnt;
    push_expected();
    pulse_start();
    if (restart_mid) begin
      repeat (600) @(negedge clk);
      pulse_start();
    end
    wait_done(budget);
    check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'd384);
    check({tag, "_reads"},  32'(cmd1_cnt - c1), 32'(N_SEC));
    check({tag, "_adv"},    32'(cmd2_cnt - c2), 32'd1536);
    check({tag, "_done"},   32'(done_cnt - d0), 32'd1);
    check({tag, "_qleft"},  32'(exp_addr_q.size()), 32'd0);
    repeat (30) @(negedge clk);
    check({tag, "_busy_after"},   32'(busy), 32'd0);
    check({tag, "_writes_after"}, 32'(wr_cnt - wr0), 32'd384);
  endtask

  initial begin
    int wr0, c1;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Card still initialising: nothing may be read until sd_busy falls
    card_hold = 1'b1;
    c1 = cmd1_cnt;
    push_expected();
    pulse_start();
    repeat (100) @(negedge clk);
    check("init_no_read", 32'(cmd1_cnt - c1), 32'd0);
    check("init_busy", 32'(busy), 32'd1);
    card_hold = 1'b0;
    wait_done(20000);
    check("init_reads", 32'(cmd1_cnt - c1), 32'(N_SEC));
    check("init_qleft", 32'(exp_addr_q.size()), 32'd0);

    // Slow memory plus an ignored second start mid-copy
    stall = 7;
    full_run("stall", 30000, 1'b1);
    stall = 0;

    // Reset mid-sector, then a fresh copy from StartSector
    push_expected();
    pulse_start();
    repeat (300) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst_n = 1'b1;
    exp_addr_q.delete(); exp_data_q.delete(); exp_sec_q.delete();
    wr0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_writes", 32'(wr_cnt - wr0), 32'd0);
    full_run("recopy", 20000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
